shift_deser: RTL and testbench

SHIFT_DESER -- requirements
Module: shift_deser

---
 rtl/shift_deser.sv | 185 ++++++++++++++++++
 tb/tb_shift_deser.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_deser.sv
// rtl/shift_deser.sv - serial bit-stream deserializer with sync hunt and output FIFO (optional DESER_PARITY_EN)
module shift_deser #(
    parameter int                WIDTH = 8,
    parameter logic [WIDTH-1:0]  SYNC  = 8'hA5,
    parameter int                DEPTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             shift_in,
    input  logic             bit_en,
    input  logic             resync,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             locked,
    output logic             overflow
`ifdef DESER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam int AW = $clog2(DEPTH);

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        LOCK = 2'd1
`ifdef DESER_PARITY_EN
        ,
        PAR  = 2'd2
`endif
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] window;
    logic [CW-1:0]    cnt;
`ifdef DESER_PARITY_EN
    logic             par_is_sync;
`endif

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic [WIDTH-1:0] next_window;
    logic [WIDTH-1:0] push_word;
    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic             full;

    assign next_window = {window[WIDTH-2:0], shift_in};
    assign out_valid   = (count != '0);
    assign full        = (count == FULL_CNT);
    assign pop         = out_valid && out_ready;
    assign push_ok     = push_req && (!full || pop);
    // Head word is forced to zero while empty so out_data reads 0 after reset
    assign out_data    = out_valid ? mem[rd_ptr] : '0;

    // Decide whether a finished word is offered to the FIFO on this edge
    always_comb begin
        push_req  = 1'b0;
        push_word = next_window;
`ifdef DESER_PARITY_EN
        // The window is frozen during PAR, so it still holds the data word
        push_word = window;
        if (bit_en && !resync && state == PAR && shift_in == ^window && !par_is_sync) begin
            push_req = 1'b1;
        end
`else
        if (bit_en && !resync && state == LOCK && cnt == LAST_BIT && next_window != SYNC) begin
            push_req = 1'b1;
        end
`endif
    end

    // Framing FSM: hunt for the sync word, then count fixed-width words
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= HUNT;
            window   <= '0;
            cnt      <= '0;
            locked   <= 1'b0;
`ifdef DESER_PARITY_EN
            par_is_sync <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
`ifdef DESER_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (resync) begin
                // Partial word is abandoned; the window keeps sliding for the hunt
                state  <= HUNT;
                cnt    <= '0;
                locked <= 1'b0;
                if (bit_en) begin
                    window <= next_window;
                end
            end else if (bit_en) begin
                case (state)
                    HUNT: begin
                        window <= next_window;
                        if (next_window == SYNC) begin
                            cnt <= '0;
`ifdef DESER_PARITY_EN
                            state       <= PAR;
                            par_is_sync <= 1'b1;
`else
                            state  <= LOCK;
                            locked <= 1'b1;
`endif
                        end
                    end
                    LOCK: begin
                        window <= next_window;
                        if (cnt == LAST_BIT) begin
                            cnt <= '0;
`ifdef DESER_PARITY_EN
                            state       <= PAR;
                            par_is_sync <= (next_window == SYNC);
`endif
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
`ifdef DESER_PARITY_EN
                    PAR: begin
                        if (shift_in == ^window) begin
                            state  <= LOCK;
                            locked <= 1'b1;
                        end else begin
                            state      <= HUNT;
                            locked     <= 1'b0;
                            parity_err <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    // FIFO storage needs no reset: entries are only read while counted valid
    always_ff @(posedge clk) begin
        if (!clr && push_ok) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_deser.sv
// tb/tb_shift_deser.sv - self-checking bench for shift_deser with a queue-based reference model
module tb_shift_deser;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       shift_in = 1'b0;
    logic       bit_en = 1'b0;
    logic       resync = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       locked;
    logic       overflow;

    int total = 0;
    int bad = 0;

    // reference model state
    bit         m_locked;
    logic [7:0] m_hist;
    int         m_nbits;
    logic [7:0] m_q[$];
    bit         m_ovf;

    shift_deser #(.WIDTH(8), .SYNC(8'hA5), .DEPTH(4)) dut (
        .clk(clk),
        .clr(clr),
        .shift_in(shift_in),
        .bit_en(bit_en),
        .resync(resync),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .locked(locked),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Drive one clock: inputs set well before the edge, model advanced at the edge, outputs settle by +1
    task automatic cycle(input bit c, input bit en, input bit b, input bit rs, input bit rdy);
        bit         do_pop;
        bit         have_word;
        logic [7:0] w;
        clr = c; bit_en = en; shift_in = b; resync = rs; out_ready = rdy;
        @(posedge clk);
        do_pop = (m_q.size() > 0) && rdy;
        have_word = 0;
        w = 8'h00;
        if (c) begin
            m_locked = 0; m_hist = 8'h00; m_nbits = 0; m_q.delete(); m_ovf = 0;
        end else begin
            if (en) m_hist = {m_hist[6:0], b};
            if (rs) begin
                m_locked = 0; m_nbits = 0;
            end else if (en) begin
                if (!m_locked) begin
                    if (m_hist == 8'hA5) begin m_locked = 1; m_nbits = 0; end
                end else begin
                    m_nbits++;
                    if (m_nbits == 8) begin
                        m_nbits = 0;
                        if (m_hist != 8'hA5) begin have_word = 1; w = m_hist; end
                    end
                end
            end
            if (do_pop) void'(m_q.pop_front());
            if (have_word) begin
                if (m_q.size() < 4) m_q.push_back(w);
                else m_ovf = 1;
            end
        end
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit rdy);
        logic [7:0] t;
        t = v;
        for (int i = 7; i >= 0; i--) cycle(1'b0, 1'b1, t[i], 1'b0, rdy);
    endtask

    task automatic do_reset;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        do_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", locked); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", out_data); end
    endtask

    task automatic test_basic;
        logic [7:0] s;
        do_reset();
        s = 8'hA5;
        for (int i = 7; i >= 1; i--) cycle(1'b0, 1'b1, s[i], 1'b0, 1'b0);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL basic_lock_early got=%b want=0", locked); end
        cycle(1'b0, 1'b1, s[0], 1'b0, 1'b0);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL basic_lock_8th got=%b want=1", locked); end
        s = 8'h3C;
        for (int i = 7; i >= 1; i--) cycle(1'b0, 1'b1, s[i], 1'b0, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_early got=%b want=0", out_valid); end
        cycle(1'b0, 1'b1, s[0], 1'b0, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", out_valid); end
        total++; if (out_data !== 8'h3C) begin bad++; $display("FAIL basic_data got=%h want=3c", out_data); end
    endtask

    task automatic test_overflow;
        logic [7:0] w[5];
        do_reset();
        send_byte(8'hA5, 1'b0);
        for (int k = 0; k < 5; k++) begin
            do w[k] = 8'($urandom_range(0, 255)); while (w[k] == 8'hA5);
            send_byte(w[k], 1'b0);
            if (k == 3) begin
                total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_at4 got=%b want=0", overflow); end
            end
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_at5 got=%b want=1", overflow); end
        for (int k = 0; k < 4; k++) begin
            total++; if (out_valid !== 1'b1 || out_data !== w[k]) begin
                bad++; $display("FAIL ovf_drain%0d got=%b/%h want=1/%h", k, out_valid, out_data, w[k]);
            end
            // hold ready low one cycle first to check out_data stays put
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            total++; if (out_data !== w[k]) begin bad++; $display("FAIL ovf_hold%0d got=%h want=%h", k, out_data, w[k]); end
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b want=0", out_valid); end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_empty_pop got=%b/%b want=0/1", out_valid, overflow);
        end
    endtask

    task automatic test_full_pop;
        logic [7:0] w[5];
        logic [7:0] t;
        do_reset();
        send_byte(8'hA5, 1'b0);
        for (int k = 0; k < 5; k++) begin
            do w[k] = 8'($urandom_range(0, 255)); while (w[k] == 8'hA5);
        end
        for (int k = 0; k < 4; k++) send_byte(w[k], 1'b0);
        t = w[4];
        for (int i = 7; i >= 1; i--) cycle(1'b0, 1'b1, t[i], 1'b0, 1'b0);
        cycle(1'b0, 1'b1, t[0], 1'b0, 1'b1);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullpop_ovf got=%b want=0", overflow); end
        for (int k = 1; k < 5; k++) begin
            total++; if (out_valid !== 1'b1 || out_data !== w[k]) begin
                bad++; $display("FAIL fullpop_drain%0d got=%b/%h want=1/%h", k, out_valid, out_data, w[k]);
            end
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fullpop_empty got=%b want=0", out_valid); end
    endtask

    task automatic test_sync_in_lock;
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'hA5, 1'b0);
        total++; if (locked !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL synclock got=%b/%b want=1/0", locked, out_valid);
        end
        send_byte(8'h42, 1'b0);
        total++; if (out_valid !== 1'b1 || out_data !== 8'h42) begin
            bad++; $display("FAIL synclock_word got=%b/%h want=1/42", out_valid, out_data);
        end
    endtask

    task automatic test_resync;
        do_reset();
        send_byte(8'hA5, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL resync_locked got=%b want=0", locked); end
        send_byte(8'hA5, 1'b0);
        total++; if (locked !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL resync_relock got=%b/%b want=1/0", locked, out_valid);
        end
        send_byte(8'h66, 1'b0);
        total++; if (out_valid !== 1'b1 || out_data !== 8'h66) begin
            bad++; $display("FAIL resync_word got=%b/%h want=1/66", out_valid, out_data);
        end
    endtask

    task automatic test_clr_mid;
        do_reset();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        total++; if (out_valid !== 1'b0 || locked !== 1'b0 || out_data !== 8'h00) begin
            bad++; $display("FAIL clrmid got=%b/%b/%h want=0/0/00", out_valid, locked, out_data);
        end
        send_byte(8'hA5, 1'b0);
        send_byte(8'h11, 1'b0);
        total++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            bad++; $display("FAIL clrmid_word got=%b/%h want=1/11", out_valid, out_data);
        end
    endtask

    task automatic test_random;
        logic [7:0] cur;
        int         idx;
        bit         en, rs, rdy, c;
        logic [7:0] exp_data;
        do_reset();
        cur = 8'hA5;
        idx = 7;
        for (int n = 0; n < 3000; n++) begin
            en  = ($urandom_range(0, 9) < 8);
            rs  = ($urandom_range(0, 199) == 0);
            c   = ($urandom_range(0, 999) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            cycle(c, en, cur[idx], rs, rdy);
            if (en) begin
                if (idx == 0) begin
                    idx = 7;
                    cur = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
                end else begin
                    idx--;
                end
            end
            exp_data = (m_q.size() > 0) ? m_q[0] : 8'h00;
            total++; if (out_valid !== (m_q.size() > 0)) begin
                bad++; $display("FAIL rnd_valid n=%0d got=%b want=%b", n, out_valid, m_q.size() > 0);
            end
            total++; if (out_data !== exp_data) begin
                bad++; $display("FAIL rnd_data n=%0d got=%h want=%h", n, out_data, exp_data);
            end
            total++; if (locked !== m_locked) begin
                bad++; $display("FAIL rnd_locked n=%0d got=%b want=%b", n, locked, m_locked);
            end
            total++; if (overflow !== m_ovf) begin
                bad++; $display("FAIL rnd_overflow n=%0d got=%b want=%b", n, overflow, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_sync_in_lock();
        test_resync();
        test_clr_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
